// File: rtl/bram_port_arbiter.sv
// Round-robin merge of two client request streams onto a single block-RAM port.
// A tag FIFO records each grant so RAM responses go back to the issuing client in order.
module bram_port_arbiter #(
    parameter int Width     = 8,
    parameter int AddrWidth = 8,
    parameter int TagDepth  = 4,
    parameter int TagPtrW   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [Width+AddrWidth:0]     c0_req,
    input  logic                         c0_req_valid,
    output logic                         c0_req_bp,
    output logic [Width-1:0]             c0_resp,
    output logic                         c0_resp_valid,
    input  logic                         c0_resp_bp,
    input  logic [Width+AddrWidth:0]     c1_req,
    input  logic                         c1_req_valid,
    output logic                         c1_req_bp,
    output logic [Width-1:0]             c1_resp,
    output logic                         c1_resp_valid,
    input  logic                         c1_resp_bp,
    output logic [Width+AddrWidth:0]     ram_req,
    output logic                         ram_req_valid,
    input  logic                         ram_req_bp,
    input  logic [Width-1:0]             ram_resp,
    input  logic                         ram_resp_valid,
    output logic                         ram_resp_bp,
    output logic                         protocol_err
);

    localparam logic [TagPtrW:0]   CountFull = (TagPtrW+1)'(TagDepth);
    localparam logic [TagPtrW:0]   CountOne  = (TagPtrW+1)'(1);
    localparam logic [TagPtrW-1:0] PtrOne    = TagPtrW'(1);

    logic                     last_grant;
    logic [TagPtrW-1:0]       wr_ptr;
    logic [TagPtrW-1:0]       rd_ptr;
    logic [TagPtrW:0]         count;
    logic                     tag_mem [TagDepth];

    logic                     fifo_empty;
    logic                     head_tag;
    logic                     pop;
    logic                     load_en;
    logic                     grant_valid;
    logic                     grant_id;
    logic [Width+AddrWidth:0] grant_req;

    assign c0_resp = ram_resp;
    assign c1_resp = ram_resp;

    // Pop may free the last tag slot, so a full FIFO can still accept a grant in the same cycle.
    always_comb begin
        fifo_empty    = (count == '0);
        head_tag      = tag_mem[rd_ptr];
        c0_resp_valid = ram_resp_valid & ~fifo_empty & ~head_tag;
        c1_resp_valid = ram_resp_valid & ~fifo_empty & head_tag;
        ram_resp_bp   = ~fifo_empty & (head_tag ? c1_resp_bp : c0_resp_bp);
        pop           = ram_resp_valid & ~ram_resp_bp & ~fifo_empty;
        load_en       = (~ram_req_valid | ~ram_req_bp) & ((count < CountFull) | pop);

        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (load_en) begin
            if (c0_req_valid && c1_req_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant;
            end else if (c0_req_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (c1_req_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
        grant_req = grant_id ? c1_req : c0_req;
        c0_req_bp = ~(grant_valid & ~grant_id);
        c1_req_bp = ~(grant_valid & grant_id);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_req       <= '0;
            ram_req_valid <= 1'b0;
            last_grant    <= 1'b1;
        end else if (grant_valid) begin
            ram_req       <= grant_req;
            ram_req_valid <= 1'b1;
            last_grant    <= grant_id;
        end else if (ram_req_valid && !ram_req_bp) begin
            ram_req_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < TagDepth; i++) begin
                tag_mem[i] <= 1'b0;
            end
        end else begin
            if (grant_valid) begin
                tag_mem[wr_ptr] <= grant_id;
                wr_ptr          <= wr_ptr + PtrOne;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrOne;
            end
            case ({grant_valid, pop})
                2'b10:   count <= count + CountOne;
                2'b01:   count <= count - CountOne;
                default: count <= count;
            endcase
        end
    end

    // A response with nothing outstanding is swallowed and flagged until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            protocol_err <= 1'b0;
        end else if (ram_resp_valid && fifo_empty) begin
            protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter; expected RAM requests and client responses
// are queued at issue time and popped by a monitor whenever a transfer occurs.
module tb_bram_port_arbiter;

    localparam int W  = 8;
    localparam int AW = 8;
    localparam int RW = W + AW + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] c0_req, c1_req, ram_req;
    logic          c0_req_valid, c0_req_bp, c1_req_valid, c1_req_bp;
    logic [W-1:0]  c0_resp, c1_resp, ram_resp;
    logic          c0_resp_valid, c0_resp_bp, c1_resp_valid, c1_resp_bp;
    logic          ram_req_valid, ram_req_bp, ram_resp_valid, ram_resp_bp;
    logic          protocol_err;

    logic          auto_resp;
    logic          man_resp_valid;
    logic [W-1:0]  man_resp;

    int checks = 0;
    int errors = 0;

    logic [RW-1:0] exp_ram [$];
    logic [W-1:0]  exp_c0  [$];
    logic [W-1:0]  exp_c1  [$];

    always #5 clk = ~clk;

    // In auto mode the RAM echoes the data field back in the same cycle the request transfers.
    assign ram_resp_valid = auto_resp ? ram_req_valid : man_resp_valid;
    assign ram_resp       = auto_resp ? ram_req[W:1] : man_resp;

    bram_port_arbiter #(.Width(W), .AddrWidth(AW), .TagDepth(4), .TagPtrW(2)) dut (
        .clk(clk), .reset(reset),
        .c0_req(c0_req), .c0_req_valid(c0_req_valid), .c0_req_bp(c0_req_bp),
        .c0_resp(c0_resp), .c0_resp_valid(c0_resp_valid), .c0_resp_bp(c0_resp_bp),
        .c1_req(c1_req), .c1_req_valid(c1_req_valid), .c1_req_bp(c1_req_bp),
        .c1_resp(c1_resp), .c1_resp_valid(c1_resp_valid), .c1_resp_bp(c1_resp_bp),
        .ram_req(ram_req), .ram_req_valid(ram_req_valid), .ram_req_bp(ram_req_bp),
        .ram_resp(ram_resp), .ram_resp_valid(ram_resp_valid), .ram_resp_bp(ram_resp_bp),
        .protocol_err(protocol_err)
    );

    function automatic logic [W-1:0] dataOf(input logic [RW-1:0] r);
        return r[W:1];
    endfunction

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic checkData(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkReq(input string name, input logic [RW-1:0] actual, input logic [RW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v0, input logic [RW-1:0] r0,
                                 input logic v1, input logic [RW-1:0] r1, input logic rbp);
        c0_req_valid = v0;
        c0_req       = r0;
        c1_req_valid = v1;
        c1_req       = r1;
        ram_req_bp   = rbp;
    endtask

    task automatic applyResponse(input logic v, input logic [W-1:0] d, input logic bp0, input logic bp1);
        man_resp_valid = v;
        man_resp       = d;
        c0_resp_bp     = bp0;
        c1_resp_bp     = bp1;
    endtask

    // Monitor: every completed transfer must match the head of its expectation queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (ram_req_valid && !ram_req_bp) begin
                if (exp_ram.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL ram_req unexpected: got 0x%0h, expected none", ram_req);
                end else begin
                    checkReq("ram_req order", ram_req, exp_ram.pop_front());
                end
            end
            if (c0_resp_valid && !c0_resp_bp) begin
                if (exp_c0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL c0_resp unexpected: got 0x%0h, expected none", c0_resp);
                end else begin
                    checkData("c0_resp order", c0_resp, exp_c0.pop_front());
                end
            end
            if (c1_resp_valid && !c1_resp_bp) begin
                if (exp_c1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL c1_resp unexpected: got 0x%0h, expected none", c1_resp);
                end else begin
                    checkData("c1_resp order", c1_resp, exp_c1.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [RW-1:0] a0, a1, b1, b2, r0b, r1b, q0, q1;
        a0  = {8'h21, 8'h3C, 1'b0};
        a1  = {8'h42, 8'hC3, 1'b1};
        b1  = {8'h07, 8'h77, 1'b0};
        b2  = {8'h08, 8'h88, 1'b1};
        r0b = {8'h30, 8'h0F, 1'b1};
        r1b = {8'h31, 8'hF0, 1'b0};
        q0  = {8'h50, 8'h55, 1'b0};
        q1  = {8'h51, 8'hAA, 1'b1};

        reset     = 1'b1;
        auto_resp = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        applyResponse(1'b0, '0, 1'b0, 1'b0);

        // Reset state
        nextCycle();
        nextCycle();
        checkReq("reset ram_req", ram_req, '0);
        checkOutput("reset ram_req_valid", ram_req_valid, 1'b0);
        checkOutput("reset protocol_err", protocol_err, 1'b0);
        checkOutput("reset c0_req_bp idle", c0_req_bp, 1'b1);
        checkOutput("reset ram_resp_bp", ram_resp_bp, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Single c0 write, response routed to c0
        nextCycle();
        applyStimulus(1'b1, 17'h0B4B, 1'b0, '0, 1'b0);
        exp_ram.push_back(17'h0B4B);
        settle();
        checkOutput("t1 c0_req_bp", c0_req_bp, 1'b0);
        checkOutput("t1 c1_req_bp", c1_req_bp, 1'b1);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        settle();
        checkOutput("t1 ram_req_valid T+1", ram_req_valid, 1'b1);
        checkReq("t1 ram_req T+1", ram_req, 17'h0B4B);
        nextCycle();
        applyResponse(1'b1, 8'h00, 1'b0, 1'b0);
        exp_c0.push_back(8'h00);
        settle();
        checkOutput("t1 c0_resp_valid", c0_resp_valid, 1'b1);
        checkOutput("t1 c1_resp_valid", c1_resp_valid, 1'b0);
        checkOutput("t1 ram_req drained", ram_req_valid, 1'b0);
        nextCycle();
        applyResponse(1'b0, '0, 1'b0, 1'b0);

        // Reset pulse restores client 0 priority, then alternating grants at full rate
        nextCycle();
        reset = 1'b1;
        #2;
        reset     = 1'b0;
        auto_resp = 1'b1;
        for (int k = 0; k < 6; k++) begin
            nextCycle();
            applyStimulus(1'b1, a0, 1'b1, a1, 1'b0);
            if (k % 2 == 0) begin
                exp_ram.push_back(a0);
                exp_c0.push_back(dataOf(a0));
            end else begin
                exp_ram.push_back(a1);
                exp_c1.push_back(dataOf(a1));
            end
            settle();
            checkOutput("t2 c0_req_bp alternate", c0_req_bp, (k % 2 == 1));
            checkOutput("t2 c1_req_bp alternate", c1_req_bp, (k % 2 == 0));
        end
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        nextCycle();
        auto_resp = 1'b0;

        // RAM backpressure holds the registered request and blocks all grants
        nextCycle();
        applyStimulus(1'b1, 17'h0B4B, 1'b0, '0, 1'b0);
        exp_ram.push_back(17'h0B4B);
        settle();
        checkOutput("t3 c0_req_bp grant", c0_req_bp, 1'b0);
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            applyStimulus(1'b1, b1, 1'b1, b2, 1'b1);
            settle();
            checkReq("t3 ram_req held", ram_req, 17'h0B4B);
            checkOutput("t3 ram_req_valid held", ram_req_valid, 1'b1);
            checkOutput("t3 c0_req_bp stall", c0_req_bp, 1'b1);
            checkOutput("t3 c1_req_bp stall", c1_req_bp, 1'b1);
        end
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        nextCycle();
        applyResponse(1'b1, 8'h5A, 1'b0, 1'b0);
        exp_c0.push_back(8'h5A);
        settle();
        checkOutput("t3 c0_resp_valid", c0_resp_valid, 1'b1);
        nextCycle();
        applyResponse(1'b0, '0, 1'b0, 1'b0);

        // Tags [1,0]: stalled c1 head blocks c0's response
        nextCycle();
        applyStimulus(1'b1, r0b, 1'b1, r1b, 1'b0);
        exp_ram.push_back(r1b);
        settle();
        checkOutput("t5 c1_req_bp win", c1_req_bp, 1'b0);
        checkOutput("t5 c0_req_bp lose", c0_req_bp, 1'b1);
        nextCycle();
        applyStimulus(1'b1, r0b, 1'b0, '0, 1'b0);
        exp_ram.push_back(r0b);
        settle();
        checkOutput("t5 c0_req_bp second", c0_req_bp, 1'b0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            nextCycle();
            applyResponse(1'b1, 8'h11, 1'b0, 1'b1);
            settle();
            checkOutput("t5 ram_resp_bp stalled", ram_resp_bp, 1'b1);
            checkOutput("t5 c0_resp_valid blocked", c0_resp_valid, 1'b0);
            checkOutput("t5 c1_resp_valid head", c1_resp_valid, 1'b1);
        end
        nextCycle();
        applyResponse(1'b1, 8'h11, 1'b0, 1'b0);
        exp_c1.push_back(8'h11);
        settle();
        checkOutput("t5 ram_resp_bp released", ram_resp_bp, 1'b0);
        nextCycle();
        applyResponse(1'b1, 8'h22, 1'b0, 1'b0);
        exp_c0.push_back(8'h22);
        settle();
        checkOutput("t5 c0_resp_valid after", c0_resp_valid, 1'b1);
        checkOutput("t5 c1_resp_valid after", c1_resp_valid, 1'b0);
        nextCycle();
        applyResponse(1'b0, '0, 1'b0, 1'b0);

        // Silent RAM: four grants fill the tag FIFO
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            applyStimulus(1'b1, q0, 1'b1, q1, 1'b0);
            exp_ram.push_back((k % 2 == 0) ? q1 : q0);
            settle();
            checkOutput("t4 c1_req_bp fill", c1_req_bp, (k % 2 == 1));
            checkOutput("t4 c0_req_bp fill", c0_req_bp, (k % 2 == 0));
        end
        for (int k = 0; k < 2; k++) begin
            nextCycle();
            settle();
            checkOutput("t4 c0_req_bp full", c0_req_bp, 1'b1);
            checkOutput("t4 c1_req_bp full", c1_req_bp, 1'b1);
        end
        checkOutput("t4 ram_req drained", ram_req_valid, 1'b0);
        nextCycle();
        applyResponse(1'b1, 8'h40, 1'b0, 1'b0);
        exp_c1.push_back(8'h40);
        exp_ram.push_back(q1);
        settle();
        checkOutput("t4 c1_resp_valid pop", c1_resp_valid, 1'b1);
        checkOutput("t4 c1_req_bp pop grant", c1_req_bp, 1'b0);
        checkOutput("t4 c0_req_bp pop grant", c0_req_bp, 1'b1);
        nextCycle();
        applyResponse(1'b0, '0, 1'b0, 1'b0);
        settle();
        checkOutput("t4 c0_req_bp still full", c0_req_bp, 1'b1);
        checkOutput("t4 c1_req_bp still full", c1_req_bp, 1'b1);
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
            applyResponse(1'b1, 8'h41 + 8'(k), 1'b0, 1'b0);
            if (k % 2 == 0) exp_c0.push_back(8'h41 + 8'(k));
            else            exp_c1.push_back(8'h41 + 8'(k));
            settle();
            checkOutput("t4 drain c0_resp_valid", c0_resp_valid, (k % 2 == 0));
        end
        nextCycle();
        applyResponse(1'b0, '0, 1'b0, 1'b0);

        // Orphan response sets the sticky error; async reset clears it without a clock edge
        nextCycle();
        applyResponse(1'b1, 8'hEE, 1'b0, 1'b0);
        settle();
        checkOutput("t6 ram_resp_bp empty", ram_resp_bp, 1'b0);
        checkOutput("t6 c0_resp_valid empty", c0_resp_valid, 1'b0);
        checkOutput("t6 c1_resp_valid empty", c1_resp_valid, 1'b0);
        checkOutput("t6 protocol_err before edge", protocol_err, 1'b0);
        nextCycle();
        applyResponse(1'b0, '0, 1'b0, 1'b0);
        settle();
        checkOutput("t6 protocol_err set", protocol_err, 1'b1);
        nextCycle();
        applyStimulus(1'b1, b1, 1'b0, '0, 1'b0);
        settle();
        checkOutput("t6 protocol_err sticky", protocol_err, 1'b1);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("t6 ram_req_valid in flight", ram_req_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6 reset ram_req_valid", ram_req_valid, 1'b0);
        checkOutput("t6 reset protocol_err", protocol_err, 1'b0);
        checkReq("t6 reset ram_req", ram_req, '0);
        #3;
        reset = 1'b0;
        nextCycle();

        checkCount("leftover ram_req expectations", exp_ram.size(), 0);
        checkCount("leftover c0_resp expectations", exp_c0.size(), 0);
        checkCount("leftover c1_resp expectations", exp_c1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
